store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the MEM-stage store datapath and the data memory write port. Accepts byte-enabled stores from the pipeline in one cycle, queues up to DEPTH of them, and drains them in order to DM at one write per cycle. Loads read DM directly; the block merges bytes from pending stores into the load result so software never observes stale data.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; asserted when low
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept (not full)
- st_pc  in  32  PC of store instruction, carried to DM for write logging
- st_addr  in  32  byte address; bits [1:0] ignored for storage, the lanes are given by st_be
- st_data  in  32  lane-aligned store data
- st_be  in  4  byte enables; 4'b0000 is accepted and discarded (no push)
- ld_addr  in  32  load byte address (word compare on [31:2])
- dm_dout  in  32  DM read data for ld_addr's word
- ld_data  out  32  load word after forwarding merge
- ld_stall  out  1  load must wait (only without STORE_BUF_FWD_EN)
- dm_we  out  1  write head entry this cycle
- dm_ready  in  1  DM accepts write at this edge
- dm_pc, dm_addr, dm_din  out  32 each  head entry pc, word address ({addr[31:2],2'b00}), data
- dm_be  out  4  head byte enables
- sb_empty  out  1  no pending stores (used for halt/syscall drain)

## Operation
- Circular FIFO: head/tail pointers log2(DEPTH) bits, count log2(DEPTH)+1 bits; wrap by pointer overflow.
- Push when st_valid & st_ready & |st_be; entry = {pc, addr[31:2], data, be, valid}.
- st_ready = (count != DEPTH), from registered count only; a same-cycle pop does not free a slot for a same-cycle push.
- dm_we = !sb_empty; dm_* driven combinationally from head. Pop at edge when dm_we & dm_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Forwarding merge, per byte lane k: youngest valid entry with addr[31:2]==ld_addr[31:2] and be[k]=1 supplies byte k; otherwise dm_dout byte k. The head entry is included even in the cycle it pops.
- No coalescing: two stores to same word occupy two entries, written in order.
- Reset (any time, including mid-drain): all valid bits, pointers, count cleared; pending stores dropped.

## Timing
- Reset values: st_ready=1, dm_we=0, sb_empty=1, ld_stall=0, dm_*=0 (head fields cleared), ld_data=dm_dout.
- Store accepted at edge N is on dm_* during cycle N+1 earliest; written into DM at edge N+1 if dm_ready.
- Forwarding visible from cycle N+1; ld_data is combinational from ld_addr, dm_dout and buffer state (no added latency).
- With dm_ready held high, a full buffer sustains one push and one pop per cycle after first drain.
- Full: st_ready low; pipeline stalls; st_* must be held stable until accepted.

## Configuration
- STORE_BUF_FWD_EN defined: byte merge as above, ld_stall tied 0.
- Undefined: no merge, ld_data=dm_dout; ld_stall=1 whenever any valid entry matches ld_addr[31:2] (regardless of be), deasserting once those entries drain.

## Structure
- Package sb_pkg: entry struct (pc, waddr[29:0], data, be, valid), DEPTH_LOG2 helper, BE_WORD=4'b1111 constant.
- One sub-module: sb_fwd_merge (combinational per-lane youngest-match select), instantiated only under STORE_BUF_FWD_EN.

## Test plan
- Reset low mid-operation with 3 entries queued -> next cycle sb_empty=1, dm_we=0, st_ready=1; no further DM writes.
- Push sw 0x0000_0010 data 0xDEADBEEF be 1111, dm_ready=1 -> cycle after accept dm_we=1, dm_addr=0x10, dm_din=0xDEADBEEF; sb_empty one cycle later.
- dm_ready=0, push 4 stores -> st_ready=0 after 4th; 5th held; raise dm_ready -> drains in order 1..5, 5th accepted the cycle after first pop.
- Queue sw 0x20=0x11223344 then sb 0x21 data 0x0000AA00 be 0010, dm_dout=0 for 0x20 -> ld_data=0x1122AA44 (FWD_EN); without macro ld_stall=1 until both drained, then ld_data=dm_dout.
- Push with st_be=0000 -> no entry, sb_empty stays 1, dm_we stays 0.
- Full buffer, dm_ready=1, st_valid=1 continuous -> exactly one push and one pop per cycle after the first cycle, count stays at DEPTH-1/DEPTH, never overflows.

Source files
------------

// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared types and constants for the store buffer.
//   sb_entry_t  : one queued store (pc, word address, data, byte enables, valid)
//   BE_WORD     : byte-enable pattern of a full-word store
//   depth_log2  : pointer width for a given queue depth
// -----------------------------------------------------------------------------
package sb_pkg;

  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [31:0] pc;
    logic [29:0] waddr;   // byte address [31:2]
    logic [31:0] data;    // lane-aligned
    logic [3:0]  be;
    logic        valid;
  } sb_entry_t;

  function automatic int depth_log2(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// -----------------------------------------------------------------------------
// sb_fwd_merge
// Combinational load-forwarding merge. For each byte lane, the youngest valid
// queued store to the load's word that enables that lane supplies the byte;
// lanes no store covers come from the memory read data.
// Ports:
//   entries   in  queue storage, indexed by physical slot
//   head      in  slot of the oldest entry
//   ld_waddr  in  load word address (byte address [31:2])
//   dm_dout   in  memory read data for that word
//   ld_data   out merged load word
// -----------------------------------------------------------------------------
import sb_pkg::*;

module sb_fwd_merge #(
  parameter int DEPTH = 4,
  parameter int PTR_W = depth_log2(DEPTH)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [PTR_W-1:0] head,
  input  logic [29:0]      ld_waddr,
  input  logic [31:0]      dm_dout,
  output logic [31:0]      ld_data
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional update, otherwise synthesis infers a latch.
    ld_data = dm_dout;
    idx     = head;
    // Walk oldest to youngest so a younger match overwrites an older one.
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (entries[idx].valid && (entries[idx].waddr == ld_waddr)) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].be[b]) begin
            ld_data[8*b +: 8] = entries[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Posted-write FIFO between the MEM-stage store path and the data memory
// write port. Stores are accepted in one cycle, held in order, and drained
// to DM one per cycle. Loads read DM directly and are either merged with
// pending store bytes or stalled while a matching store is queued.
//
// Build option: STORE_BUF_FWD_EN
//   defined   - byte-lane forwarding merge into ld_data, ld_stall tied low
//   undefined - ld_data = dm_dout, ld_stall high while any queued store
//               targets the load's word
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   st_valid/st_ready          store handshake (ready = not full)
//   st_pc/st_addr/st_data/st_be  store request; be==0 is accepted and dropped
//   ld_addr, dm_dout           load address and DM read data for its word
//   ld_data, ld_stall          load result and load stall
//   dm_we/dm_ready             head-entry write request and DM acceptance
//   dm_pc/dm_addr/dm_din/dm_be head entry fields (word-aligned address)
//   sb_empty                   no pending stores
// -----------------------------------------------------------------------------
import sb_pkg::*;

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_pc,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_be,
  input  logic [31:0] ld_addr,
  input  logic [31:0] dm_dout,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        dm_we,
  input  logic        dm_ready,
  output logic [31:0] dm_pc,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic [3:0]  dm_be,
  output logic        sb_empty
);

  localparam int PTR_W = depth_log2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        mem_q [DEPTH];
  sb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  sb_entry_t        head_entry;

  // Byte offsets are carried by the byte enables / not needed for word compare.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // Ready comes from the registered count only, so a pop in this cycle does
  // not open a slot for a push in the same cycle.
  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign sb_empty = (count_q == '0);
  assign dm_we    = !sb_empty;

  assign push = st_valid && st_ready && (|st_be);
  assign pop  = dm_we && dm_ready;

  // Popped slots are cleared, so an empty buffer presents all-zero dm_* fields.
  assign head_entry = mem_q[head_q];
  assign dm_pc      = head_entry.pc;
  assign dm_addr    = {head_entry.waddr, 2'b00};
  assign dm_din     = head_entry.data;
  assign dm_be      = head_entry.be;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (pop) begin
      mem_d[head_q] = '0;
      head_d        = head_q + PTR_W'(1);
    end

    // A push and a pop never target the same slot: that needs head==tail,
    // which means empty (no pop) or full (no push).
    if (push) begin
      mem_d[tail_q] = '{pc:    st_pc,
                        waddr: st_addr[31:2],
                        data:  st_data,
                        be:    st_be,
                        valid: 1'b1};
      tail_d        = tail_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the entry array is reset along with the pointers because valid
      // bits gate forwarding/stall and the head fields drive dm_* directly;
      // pending stores are intentionally dropped.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef STORE_BUF_FWD_EN
  sb_fwd_merge #(
    .DEPTH (DEPTH)
  ) u_fwd_merge (
    .entries  (mem_q),
    .head     (head_q),
    .ld_waddr (ld_addr[31:2]),
    .dm_dout  (dm_dout),
    .ld_data  (ld_data)
  );

  assign ld_stall = 1'b0;
`else
  // Any queued store to the load's word blocks the load, whatever its lanes.
  always_comb begin
    ld_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid && (mem_q[i].waddr == ld_addr[31:2])) begin
        ld_stall = 1'b1;
      end
    end
  end

  assign ld_data = dm_dout;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Directed bench for store_buffer (DEPTH=4). Inputs change 1ns after the
// rising edge; outputs are compared on the falling edge. DM writes are logged
// on the falling edge whenever dm_we & dm_ready will complete at the next edge.
// Works with or without STORE_BUF_FWD_EN defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_pc = '0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_be = '0;
  logic [31:0] ld_addr = 32'h0000_0010;
  logic [31:0] dm_dout = 32'h1234_5678;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        dm_we;
  logic        dm_ready = 1'b0;
  logic [31:0] dm_pc, dm_addr, dm_din;
  logic [3:0]  dm_be;
  logic        sb_empty;

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [31:0] wr_pc   [$];
  logic [31:0] wr_be   [$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_pc    (st_pc),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_be    (st_be),
    .ld_addr  (ld_addr),
    .dm_dout  (dm_dout),
    .ld_data  (ld_data),
    .ld_stall (ld_stall),
    .dm_we    (dm_we),
    .dm_ready (dm_ready),
    .dm_pc    (dm_pc),
    .dm_addr  (dm_addr),
    .dm_din   (dm_din),
    .dm_be    (dm_be),
    .sb_empty (sb_empty)
  );

  always @(negedge clk) begin
    if (reset && dm_we && dm_ready) begin
      wr_addr.push_back(dm_addr);
      wr_data.push_back(dm_din);
      wr_pc.push_back(dm_pc);
      wr_be.push_back({28'h0, dm_be});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_store(input logic [31:0] pc, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
    int n;
    n        = 0;
    st_valid = 1'b1;
    st_pc    = pc;
    st_addr  = addr;
    st_data  = data;
    st_be    = be;
    @(negedge clk);
    while (!st_ready && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!st_ready) begin
      total++;
      bad++;
      $error("FAIL push_timeout observed=%0d expected=ready", n);
    end
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!sb_empty && n < 40) begin
      tick();
      @(negedge clk);
      n++;
    end
    check(tag, {31'h0, sb_empty}, 32'h1);
    tick();
  endtask

  initial begin
    int base;

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_st_ready", {31'h0, st_ready}, 32'h1);
    check("rst_dm_we",    {31'h0, dm_we},    32'h0);
    check("rst_sb_empty", {31'h0, sb_empty}, 32'h1);
    check("rst_ld_stall", {31'h0, ld_stall}, 32'h0);
    check("rst_dm_addr",  dm_addr,           32'h0);
    check("rst_dm_din",   dm_din,            32'h0);
    check("rst_dm_pc",    dm_pc,             32'h0);
    check("rst_dm_be",    {28'h0, dm_be},    32'h0);
    check("rst_ld_data",  ld_data,           32'h1234_5678);
    tick();
    reset = 1'b1;
    tick();

    // ---------------- single word store ----------------
    dm_ready = 1'b1;
    push_store(32'h0000_0100, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    @(negedge clk);
    check("sw_dm_we",    {31'h0, dm_we},    32'h1);
    check("sw_dm_addr",  dm_addr,           32'h0000_0010);
    check("sw_dm_din",   dm_din,            32'hDEAD_BEEF);
    check("sw_dm_be",    {28'h0, dm_be},    32'hF);
    check("sw_dm_pc",    dm_pc,             32'h0000_0100);
    check("sw_not_empty",{31'h0, sb_empty}, 32'h0);
    tick();
    @(negedge clk);
    check("sw_empty",    {31'h0, sb_empty}, 32'h1);
    check("sw_we_low",   {31'h0, dm_we},    32'h0);
    check("sw_wr_count", wr_addr.size(),    32'd1);
    tick();

    // ---------------- zero byte-enable store is dropped ----------------
    push_store(32'h0000_0104, 32'h0000_0030, 32'hCAFE_F00D, 4'b0000);
    @(negedge clk);
    check("be0_empty",  {31'h0, sb_empty}, 32'h1);
    check("be0_we",     {31'h0, dm_we},    32'h0);
    tick();
    @(negedge clk);
    check("be0_count",  wr_addr.size(),    32'd1);
    tick();

    // ---------------- fill, hold 5th, drain in order ----------------
    dm_ready = 1'b0;
    base = wr_addr.size();
    for (int i = 0; i < 4; i++) begin
      push_store(32'h0000_0200 + 32'(4*i), 32'h0000_0040 + 32'(4*i), 32'(i + 1), 4'b1111);
    end
    @(negedge clk);
    check("full_ready",  {31'h0, st_ready}, 32'h0);
    check("full_we",     {31'h0, dm_we},    32'h1);
    check("full_head",   dm_addr,           32'h0000_0040);
    tick();
    st_valid = 1'b1;
    st_pc    = 32'h0000_0210;
    st_addr  = 32'h0000_0050;
    st_data  = 32'h0000_0005;
    st_be    = 4'b1111;
    @(negedge clk);
    check("hold_ready0", {31'h0, st_ready}, 32'h0);
    tick();
    @(negedge clk);
    check("hold_ready1", {31'h0, st_ready}, 32'h0);
    check("hold_nowrite", wr_addr.size(),   32'(base));
    tick();
    dm_ready = 1'b1;
    @(negedge clk);
    check("pop1_ready",  {31'h0, st_ready}, 32'h0);
    tick();
    @(negedge clk);
    check("after_pop_ready", {31'h0, st_ready}, 32'h1);
    check("after_pop_head",  dm_addr,           32'h0000_0044);
    tick();
    st_valid = 1'b0;
    wait_empty("fill_drain");
    check("fill_count", wr_addr.size(), 32'(base + 5));
    check("fill_a0", wr_addr[base+0], 32'h0000_0040);
    check("fill_d0", wr_data[base+0], 32'h0000_0001);
    check("fill_a1", wr_addr[base+1], 32'h0000_0044);
    check("fill_d1", wr_data[base+1], 32'h0000_0002);
    check("fill_d2", wr_data[base+2], 32'h0000_0003);
    check("fill_d3", wr_data[base+3], 32'h0000_0004);
    check("fill_a4", wr_addr[base+4], 32'h0000_0050);
    check("fill_d4", wr_data[base+4], 32'h0000_0005);
    check("fill_p4", wr_pc[base+4],   32'h0000_0210);

    // ---------------- forwarding / stall ----------------
    dm_ready = 1'b0;
    base = wr_addr.size();
    push_store(32'h0000_0300, 32'h0000_0020, 32'h1122_3344, 4'b1111);
    push_store(32'h0000_0304, 32'h0000_0021, 32'h0000_AA00, 4'b0010);
    ld_addr = 32'h0000_0020;
    dm_dout = 32'h0000_0000;
    @(negedge clk);
`ifdef STORE_BUF_FWD_EN
    check("fwd_merge0", ld_data, 32'h1122_AA44);
    check("fwd_stall0", {31'h0, ld_stall}, 32'h0);
`else
    check("stl_stall0", {31'h0, ld_stall}, 32'h1);
    check("stl_data0",  ld_data, 32'h0000_0000);
`endif
    tick();
    ld_addr = 32'h0000_0023;
    dm_dout = 32'hFFFF_FFFF;
    @(negedge clk);
`ifdef STORE_BUF_FWD_EN
    check("fwd_merge1", ld_data, 32'h1122_AA44);
`else
    check("stl_stall1", {31'h0, ld_stall}, 32'h1);
    check("stl_data1",  ld_data, 32'hFFFF_FFFF);
`endif
    tick();
    ld_addr = 32'h0000_0024;
    @(negedge clk);
    check("nomatch_stall", {31'h0, ld_stall}, 32'h0);
    check("nomatch_data",  ld_data, 32'hFFFF_FFFF);
    tick();
    ld_addr  = 32'h0000_0020;
    dm_ready = 1'b1;
    @(negedge clk);
`ifdef STORE_BUF_FWD_EN
    check("fwd_popcycle", ld_data, 32'h1122_AA44);
`else
    check("stl_popcycle", {31'h0, ld_stall}, 32'h1);
`endif
    tick();
    @(negedge clk);
`ifdef STORE_BUF_FWD_EN
    check("fwd_sb_only", ld_data, 32'hFFFF_AAFF);
`else
    check("stl_sb_only", {31'h0, ld_stall}, 32'h1);
    check("stl_sb_data", ld_data, 32'hFFFF_FFFF);
`endif
    tick();
    @(negedge clk);
    check("fwd_done_stall", {31'h0, ld_stall}, 32'h0);
    check("fwd_done_data",  ld_data, 32'hFFFF_FFFF);
    check("fwd_done_empty", {31'h0, sb_empty}, 32'h1);
    check("nocoal_count", wr_addr.size(), 32'(base + 2));
    check("nocoal_a0", wr_addr[base+0], 32'h0000_0020);
    check("nocoal_d0", wr_data[base+0], 32'h1122_3344);
    check("nocoal_a1", wr_addr[base+1], 32'h0000_0020);
    check("nocoal_d1", wr_data[base+1], 32'h0000_AA00);
    check("nocoal_b1", wr_be[base+1],   32'h0000_0002);
    tick();

    // ---------------- full buffer streaming ----------------
    dm_ready = 1'b0;
    base = wr_addr.size();
    for (int i = 0; i < 4; i++) begin
      push_store(32'h0000_0400, 32'h0000_0080 + 32'(4*i), 32'h0000_00A0 + 32'(i), 4'b1111);
    end
    begin
      int j;
      logic acc;
      j        = 4;
      dm_ready = 1'b1;
      st_valid = 1'b1;
      st_addr  = 32'h0000_0080 + 32'(4*j);
      st_data  = 32'h0000_00A0 + 32'(j);
      st_be    = 4'b1111;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (c == 0) check("stream_first_full", {31'h0, st_ready}, 32'h0);
        else        check("stream_ready",      {31'h0, st_ready}, 32'h1);
        check("stream_we", {31'h0, dm_we}, 32'h1);
        acc = st_ready;
        tick();
        if (acc) begin
          j++;
          st_addr = 32'h0000_0080 + 32'(4*j);
          st_data = 32'h0000_00A0 + 32'(j);
        end
      end
      st_valid = 1'b0;
    end
    wait_empty("stream_drain");
    check("stream_count", wr_addr.size(), 32'(base + 13));
    for (int i = 0; i < 13; i++) begin
      check("stream_order", wr_data[base+i], 32'h0000_00A0 + 32'(i));
    end

    // ---------------- reset mid-operation ----------------
    dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_store(32'h0000_0500, 32'h0000_00C0 + 32'(4*i), 32'h0000_0700 + 32'(i), 4'b1111);
    end
    base  = wr_addr.size();
    reset = 1'b0;
    @(negedge clk);
    check("mrst_empty", {31'h0, sb_empty}, 32'h1);
    check("mrst_we",    {31'h0, dm_we},    32'h0);
    check("mrst_ready", {31'h0, st_ready}, 32'h1);
    check("mrst_addr",  dm_addr,           32'h0);
    tick();
    reset    = 1'b1;
    dm_ready = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    check("mrst_nowrites", wr_addr.size(), 32'(base));
    check("mrst_still_empty", {31'h0, sb_empty}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
